hole_detect: RTL and testbench

HOLE_DETECT -- requirements
Module: hole_detect

---
 rtl/teeter_pkg.sv | 29 ++
 rtl/dist_cmp.sv | 51 +++++
 rtl/hole_detect.sv | 133 +++++++++++++
 tb/tb_hole_detect.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/teeter_pkg.sv
// Shared constants, FSM states and pos_list field offsets for the teeter hole detector.
// The distance test is selected by HOLE_DETECT_CIRCLE_EN (see dist_cmp).
package teeter_pkg;

  localparam int N_OBJ   = 9;
  localparam int COORD_W = 10;
  localparam int IDX_W   = 4;
  localparam int LIST_W  = 2 * N_OBJ * COORD_W;

  localparam logic [IDX_W-1:0] IDX_BALL   = 4'd0;
  localparam logic [IDX_W-1:0] IDX_FINISH = 4'd1;
  localparam logic [IDX_W-1:0] IDX_LAST   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_e;

  // y fields occupy the upper half, x fields the lower half
  function automatic int y_lsb(input int i);
    return LIST_W - COORD_W * (i + 1);
  endfunction

  function automatic int x_lsb(input int i);
    return (LIST_W / 2) - COORD_W * (i + 1);
  endfunction

endpackage

// File: rtl/dist_cmp.sv
// Combinational ball-to-object proximity test.
// Box test by default; HOLE_DETECT_CIRCLE_EN selects the Euclidean test.
module dist_cmp
  import teeter_pkg::*;
#(
  parameter int HIT_R = 12
) (
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic [COORD_W-1:0] obj_x,
  input  logic [COORD_W-1:0] obj_y,
  output logic               hit
);

  localparam int DW = COORD_W + 1;

  logic [DW-1:0] bx_w;
  logic [DW-1:0] by_w;
  logic [DW-1:0] ox_w;
  logic [DW-1:0] oy_w;
  logic [DW-1:0] dx;
  logic [DW-1:0] dy;

  assign bx_w = {1'b0, ball_x};
  assign by_w = {1'b0, ball_y};
  assign ox_w = {1'b0, obj_x};
  assign oy_w = {1'b0, obj_y};

  always_comb begin
    dx = (bx_w >= ox_w) ? bx_w - ox_w : ox_w - bx_w;
    dy = (by_w >= oy_w) ? by_w - oy_w : oy_w - by_w;
  end

`ifdef HOLE_DETECT_CIRCLE_EN
  localparam logic [21:0] R2 = 22'(HIT_R * HIT_R);

  logic [21:0] dx2;
  logic [21:0] dy2;
  logic [21:0] d2;

  assign dx2 = 22'(dx) * 22'(dx);
  assign dy2 = 22'(dy) * 22'(dy);
  assign d2  = dx2 + dy2;
  assign hit = (d2 <= R2);
`else
  localparam logic [DW-1:0] R = DW'(HIT_R);

  assign hit = (dx <= R) && (dy <= R);
`endif

endmodule

// File: rtl/hole_detect.sv
// Sequential hole scanner: tests one snapshotted object per cycle, finish first.
// Distance test chosen in dist_cmp via HOLE_DETECT_CIRCLE_EN.
module hole_detect
  import teeter_pkg::*;
#(
  parameter int LIST_LENGTH = 180,
  parameter int HIT_R       = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LIST_LENGTH-1:0] pos_list,
  input  logic                   start,
  input  logic [COORD_W-1:0]     ball_x,
  input  logic [COORD_W-1:0]     ball_y,
  output logic                   busy,
  output logic                   done,
  output logic                   hit_finish,
  output logic                   hit_hole,
  output logic [IDX_W-1:0]       hole_idx
);

  state_e state_q;
  state_e state_d;

  logic [IDX_W-1:0]       idx_q;
  logic [IDX_W-1:0]       idx_d;
  logic [LIST_LENGTH-1:0] snap_q;
  logic [LIST_LENGTH-1:0] snap_d;
  logic [COORD_W-1:0]     bx_q;
  logic [COORD_W-1:0]     bx_d;
  logic [COORD_W-1:0]     by_q;
  logic [COORD_W-1:0]     by_d;
  logic                   fin_q;
  logic                   fin_d;
  logic                   trap_q;
  logic                   trap_d;
  logic [IDX_W-1:0]       hidx_q;
  logic [IDX_W-1:0]       hidx_d;

  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic               hit;

  always_comb begin
    cur_x = '0;
    cur_y = '0;
    for (int i = 1; i < N_OBJ; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_x = snap_q[x_lsb(i) +: COORD_W];
        cur_y = snap_q[y_lsb(i) +: COORD_W];
      end
    end
  end

  dist_cmp #(
    .HIT_R(HIT_R)
  ) u_cmp (
    .ball_x(bx_q),
    .ball_y(by_q),
    .obj_x (cur_x),
    .obj_y (cur_y),
    .hit   (hit)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    bx_d    = bx_q;
    by_d    = by_q;
    fin_d   = fin_q;
    trap_d  = trap_q;
    hidx_d  = hidx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d  = pos_list;
          bx_d    = ball_x;
          by_d    = ball_y;
          fin_d   = 1'b0;
          trap_d  = 1'b0;
          hidx_d  = '0;
          idx_d   = IDX_FINISH;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (hit) begin
          hidx_d  = idx_q;
          fin_d   = (idx_q == IDX_FINISH);
          trap_d  = (idx_q != IDX_FINISH);
          state_d = ST_DONE;
        end else if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_BALL;
      fin_q   <= 1'b0;
      trap_q  <= 1'b0;
      hidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fin_q   <= fin_d;
      trap_q  <= trap_d;
      hidx_q  <= hidx_d;
    end
  end

  // snapshot is only consumed in SCAN, which is always preceded by a load
  always_ff @(posedge clk) begin
    snap_q <= snap_d;
    bx_q   <= bx_d;
    by_q   <= by_d;
  end

  assign busy       = (state_q == ST_SCAN);
  assign done       = (state_q == ST_DONE);
  assign hit_finish = fin_q;
  assign hit_hole   = trap_q;
  assign hole_idx   = hidx_q;

endmodule

// File: tb/tb_hole_detect.sv
// Self-checking bench for hole_detect: vector table, corner sequences,
// and random scans against a rule-level reference model.
module tb_hole_detect;

  localparam int HIT_R = 12;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [179:0] pos_list;
  logic [9:0]   ball_x;
  logic [9:0]   ball_y;
  logic         busy;
  logic         done;
  logic         hit_finish;
  logic         hit_hole;
  logic [3:0]   hole_idx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hole_detect #(
    .LIST_LENGTH(180),
    .HIT_R      (HIT_R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pos_list  (pos_list),
    .start     (start),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .busy      (busy),
    .done      (done),
    .hit_finish(hit_finish),
    .hit_hole  (hit_hole),
    .hole_idx  (hole_idx)
  );

  typedef struct {
    logic [179:0] pl;
    int           bx;
    int           by;
    int           exp_idx;
    int           exp_cyc;
    string        name;
  } vec_t;

  int l0x[9] = '{20, 284, 144, 400, 500, 600, 700, 800, 900};
  int l0y[9] = '{20, 10, 74, 200, 300, 100, 400, 250, 450};
  int l9x[9] = '{10, 60, 150, 280, 300, 350, 400, 450, 500};
  int l9y[9] = '{10, 140, 70, 5, 600, 600, 600, 600, 600};
  int lbx[9] = '{20, 1000, 100, 1000, 1000, 1000, 1000, 1000, 1000};
  int lby[9] = '{20, 1000, 100, 800, 700, 600, 500, 400, 300};

  logic [179:0] lvl0;
  logic [179:0] lvl9;
  logic [179:0] lvlb;
  vec_t         vecs[8];

  function automatic logic [179:0] pack(input int xs[9], input int ys[9]);
    logic [179:0] pl;
    pl = '0;
    for (int i = 0; i < 9; i++) begin
      pl[179-10*i -: 10] = 10'(ys[i]);
      pl[89-10*i -: 10]  = 10'(xs[i]);
    end
    return pl;
  endfunction

  // first object in scan order (1..8) within reach of the ball, else 0
  function automatic int model(input logic [179:0] pl, input int bx, input int by);
    for (int i = 1; i <= 8; i++) begin
      int ox;
      int oy;
      int dx;
      int dy;
      oy = int'(pl[179-10*i -: 10]);
      ox = int'(pl[89-10*i -: 10]);
      dx = (bx > ox) ? bx - ox : ox - bx;
      dy = (by > oy) ? by - oy : oy - by;
`ifdef HOLE_DETECT_CIRCLE_EN
      if (dx * dx + dy * dy <= HIT_R * HIT_R) return i;
`else
      if (dx <= HIT_R && dy <= HIT_R) return i;
`endif
    end
    return 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input logic [179:0] pl, input int bx, input int by,
                          input int exp_idx, input int exp_cyc, input string nm,
                          input logic [179:0] alt, input int alt_cyc,
                          input bit poke);
    int cyc;
    int bad;
    bit got;
    pos_list = pl;
    ball_x   = 10'(bx);
    ball_y   = 10'(by);
    start    = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    bad   = 0;
    got   = 1'b0;
    while (!got && cyc < 20) begin
      if (cyc == alt_cyc) begin
        pos_list = alt;
        ball_x   = 10'd284;
        ball_y   = 10'd10;
      end
      start = poke && (cyc < 8);
      if (done) got = 1'b1;
      else begin
        if (!busy) bad++;
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    chk({nm, ".done_cyc"}, got ? cyc : -1, exp_cyc);
    chk({nm, ".busy_gap"}, bad, 0);
    chk({nm, ".busy_done"}, int'(busy), 0);
    chk({nm, ".idx"}, int'(hole_idx), exp_idx);
    chk({nm, ".fin"}, int'(hit_finish), (exp_idx == 1) ? 1 : 0);
    chk({nm, ".trap"}, int'(hit_hole), (exp_idx >= 2) ? 1 : 0);
    tick();
    chk({nm, ".pulse"}, int'(done), 0);
    chk({nm, ".hold"}, int'(hole_idx), exp_idx);
  endtask

  initial begin
    int n;
    int exp;
    int xs[9];
    int ys[9];
    logic [179:0] pl;

    lvl0 = pack(l0x, l0y);
    lvl9 = pack(l9x, l9y);
    lvlb = pack(lbx, lby);

    vecs[0] = '{lvl0, 280, 5, 1, 2, "finish"};
    vecs[1] = '{lvl0, 150, 70, 2, 3, "trap2"};
    vecs[2] = '{lvl0, 60, 140, 0, 9, "nohit"};
`ifdef HOLE_DETECT_CIRCLE_EN
    vecs[3] = '{lvlb, 112, 88, 0, 9, "corner"};
    vecs[5] = '{lvlb, 109, 109, 0, 9, "diag"};
`else
    vecs[3] = '{lvlb, 112, 88, 2, 3, "corner"};
    vecs[5] = '{lvlb, 109, 109, 2, 3, "diag"};
`endif
    vecs[4] = '{lvlb, 113, 100, 0, 9, "edge_out"};
    vecs[6] = '{lvl0, 20, 20, 0, 9, "obj0"};
    vecs[7] = '{lvl0, 900, 450, 8, 9, "trap8"};

    rst      = 1'b1;
    start    = 1'b0;
    pos_list = '0;
    ball_x   = '0;
    ball_y   = '0;
    repeat (2) tick();
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.fin", int'(hit_finish), 0);
    chk("rst.trap", int'(hit_hole), 0);
    chk("rst.idx", int'(hole_idx), 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i])
      run_scan(vecs[i].pl, vecs[i].bx, vecs[i].by, vecs[i].exp_idx,
               vecs[i].exp_cyc, vecs[i].name, '0, 0, 1'b0);

    run_scan(lvl0, 60, 140, 0, 9, "swap", lvl9, 2, 1'b0);
    run_scan(lvl0, 60, 140, 0, 9, "poke", '0, 0, 1'b1);

    // start held high across DONE restarts immediately
    pos_list = lvl0;
    ball_x   = 10'd280;
    ball_y   = 10'd5;
    start    = 1'b1;
    tick();
    tick();
    chk("b2b.done1", int'(done), 1);
    tick();
    chk("b2b.idle", int'(busy), 0);
    chk("b2b.held", int'(hole_idx), 1);
    tick();
    chk("b2b.busy", int'(busy), 1);
    chk("b2b.clr", int'(hole_idx), 0);
    tick();
    chk("b2b.done2", int'(done), 1);
    chk("b2b.idx2", int'(hole_idx), 1);
    start = 1'b0;
    tick();

    // reset in cycle 4 of a no-hit scan
    pos_list = lvl0;
    ball_x   = 10'd60;
    ball_y   = 10'd140;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.busy", int'(busy), 0);
    chk("abort.done", int'(done), 0);
    chk("abort.fin", int'(hit_finish), 0);
    chk("abort.trap", int'(hit_hole), 0);
    chk("abort.idx", int'(hole_idx), 0);
    n = 0;
    repeat (12) begin
      tick();
      if (done || busy) n++;
    end
    chk("abort.quiet", n, 0);

    // start coincident with reset, after a held finish result
    run_scan(lvl0, 280, 5, 1, 2, "pre", '0, 0, 1'b0);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk("rststart.idx", int'(hole_idx), 0);
    chk("rststart.fin", int'(hit_finish), 0);
    chk("rststart.busy", int'(busy), 0);
    tick();
    chk("rststart.busy2", int'(busy), 0);

    for (int k = 0; k < 150; k++) begin
      int tgt;
      int bx;
      int by;
      for (int i = 0; i < 9; i++) begin
        xs[i] = int'($urandom_range(0, 1023));
        ys[i] = int'($urandom_range(0, 1023));
      end
      if (k % 10 == 0) begin
        xs[2] = xs[1] + 3;
        ys[2] = ys[1];
      end
      pl  = pack(xs, ys);
      tgt = int'($urandom_range(0, 8));
      bx  = xs[tgt] + int'($urandom_range(0, 30)) - 15;
      by  = ys[tgt] + int'($urandom_range(0, 30)) - 15;
      bx  = (bx < 0) ? 0 : (bx > 1023) ? 1023 : bx;
      by  = (by < 0) ? 0 : (by > 1023) ? 1023 : by;
      exp = model(pl, bx, by);
      run_scan(pl, bx, by, exp, (exp != 0) ? exp + 1 : 9,
               $sformatf("rnd%0d", k), '0, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
